// File: rtl/stream_packet_arbiter.sv
// Round-robin packet arbiter: N_INPUTS streams into one registered output slice, whole packets only.
// Define STREAM_ARB_WATCHDOG_EN to close a packet whose granted source stalls mid-packet.
module stream_packet_arbiter #(
  parameter int T_DATA_WIDTH    = 1,
  parameter int KEEP_WIDTH      = 3,
  parameter int N_INPUTS        = 3,
  parameter int WATCHDOG_CYCLES = 16
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [N_INPUTS-1:0][KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] s_data_in,
  input  logic [N_INPUTS-1:0][KEEP_WIDTH-1:0]                 s_keep_in,
  input  logic [N_INPUTS-1:0]                                 s_last_in,
  input  logic [N_INPUTS-1:0]                                 s_valid_in,
  output logic [N_INPUTS-1:0]                                 s_ready_out,
  output logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0]             m_data_out,
  output logic [KEEP_WIDTH-1:0]                               m_keep_out,
  output logic                                                m_last_out,
  output logic                                                m_valid_out,
  input  logic                                                m_ready_in,
  output logic [$clog2(N_INPUTS)-1:0]                         m_grant_out,
  output logic                                                wd_abort_out
);
  localparam int GW = $clog2(N_INPUTS);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef struct packed {
    logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0]                   keep;
    logic                                    last;
    logic [GW-1:0]                           grant;
  } beat_t;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_grant_q, last_grant_d, pick;
  beat_t         slice_q, slice_d;
  logic          vld_q, vld_d, wd_abort_q, wd_abort_d;
  logic          any_vld, out_open, acc, wd_fire;

  // Slice can take a beat when empty or draining this cycle.
  assign out_open = m_ready_in | ~vld_q;
  assign acc      = (state_q == BUSY) && s_valid_in[grant_q] && out_open;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_rdy
    assign s_ready_out[g] = (state_q == BUSY) && (grant_q == GW'(g)) && out_open;
  end

  // Cyclic search from last_grant+1; walking k downward lets the nearest index win.
  always_comb begin
    int idx;
    idx     = 0;
    any_vld = 1'b0;
    pick    = last_grant_q;
    for (int k = N_INPUTS; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % N_INPUTS;
      if (s_valid_in[idx]) begin
        any_vld = 1'b1;
        pick    = GW'(idx);
      end
    end
  end

`ifdef STREAM_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WATCHDOG_CYCLES + 1);
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wd_idle;

  assign wd_idle = (state_q == BUSY) && !s_valid_in[grant_q] && out_open;
  assign wd_fire = wd_idle && (wd_cnt_q == CW'(WATCHDOG_CYCLES - 1));
  assign wd_cnt_d = (wd_idle && !wd_fire) ? wd_cnt_q + CW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_cnt_q <= '0;
    else        wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    slice_d      = slice_q;
    vld_d        = vld_q & ~m_ready_in;
    wd_abort_d   = 1'b0;
    case (state_q)
      IDLE: if (any_vld) begin
        grant_d = pick;
        state_d = BUSY;
      end
      BUSY: if (acc) begin
        vld_d   = 1'b1;
        slice_d = '{data: s_data_in[grant_q], keep: s_keep_in[grant_q],
                    last: s_last_in[grant_q], grant: grant_q};
        if (s_last_in[grant_q]) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end else if (wd_fire) begin
        vld_d        = 1'b1;
        slice_d      = '{data: '0, keep: '0, last: 1'b1, grant: grant_q};
        state_d      = IDLE;
        last_grant_d = grant_q;
        wd_abort_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_INPUTS - 1);
      slice_q      <= '0;
      vld_q        <= 1'b0;
      wd_abort_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      slice_q      <= slice_d;
      vld_q        <= vld_d;
      wd_abort_q   <= wd_abort_d;
    end
  end

  assign m_data_out   = slice_q.data;
  assign m_keep_out   = slice_q.keep;
  assign m_last_out   = slice_q.last;
  assign m_grant_out  = slice_q.grant;
  assign m_valid_out  = vld_q;
  assign wd_abort_out = wd_abort_q;
endmodule

// File: doc/stream_packet_arbiter.md
STREAM_PACKET_ARBITER -- requirements
Module: stream_packet_arbiter

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 1, bits per data element.
REQ-002 SHALL have parameter KEEP_WIDTH, default 3, elements per beat (matches the S_KEEP_WIDTH of the downstream stream_rescale).
REQ-003 SHALL have parameter N_INPUTS, default 3, number of requesting streams (2..8).
REQ-004 SHALL have parameter WATCHDOG_CYCLES, default 16, mid-packet idle limit (used only with STREAM_ARB_WATCHDOG_EN).
REQ-005 Ports, one per line:
 clk  input  1  single clock, all logic on rising edge.
 rst_n  input  1  asynchronous, active-low reset.
 s_data_in  input  [N_INPUTS-1:0][KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0]  per-input beat data.
 s_keep_in  input  [N_INPUTS-1:0][KEEP_WIDTH-1:0]  per-input element enables.
 s_last_in  input  N_INPUTS  per-input end-of-packet.
 s_valid_in  input  N_INPUTS  per-input valid.
 s_ready_out  output  N_INPUTS  per-input ready.
 m_data_out  output  [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0]  muxed data to stream_rescale.
 m_keep_out  output  KEEP_WIDTH  muxed keep.
 m_last_out  output  1  muxed last.
 m_valid_out  output  1  output valid.
 m_ready_in  input  1  downstream ready.
 m_grant_out  output  $clog2(N_INPUTS)  index of input owning current output beat.
 wd_abort_out  output  1  one-cycle pulse on watchdog abort (tied 0 without macro).

Function
REQ-006 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-007 IDLE: all s_ready_out SHALL be 0; if any s_valid_in set, latch grant = first valid index searching cyclically from last_grant+1, go BUSY next edge.
REQ-008 IDLE with no valid input SHALL stay IDLE and keep last_grant unchanged.
REQ-009 BUSY: s_ready_out[grant] SHALL equal (m_ready_in | ~m_valid_out); all other ready bits 0.
REQ-010 Output SHALL be a single register slice: accepted input beat appears on m_* exactly 1 cycle after the accepting edge.
REQ-011 m_valid_out SHALL hold with data stable while m_ready_in=0; it clears after a handshake with no new accept in the same cycle.
REQ-012 Simultaneous output handshake and input accept SHALL replace the slice contents with no bubble.
REQ-013 Accepting a beat with s_last_in[grant]=1 SHALL return FSM to IDLE and set last_grant=grant; packets are never interleaved.
REQ-014 Minimum gap between packets SHALL be 1 input-side cycle (the IDLE arbitration cycle).
REQ-015 m_grant_out SHALL reflect the source of the beat currently in the slice.
REQ-016 s_keep_in=0 beats SHALL be forwarded unchanged; the arbiter does not filter keep.
REQ-017 Changes on non-granted inputs SHALL have no effect on outputs.

Reset
REQ-018 On rst_n low, immediately: FSM=IDLE, m_valid_out=0, m_last_out=0, m_keep_out=0, m_data_out=0, m_grant_out=0, s_ready_out=0, wd_abort_out=0, last_grant=N_INPUTS-1 (so input 0 wins first).
REQ-019 Reset mid-packet SHALL discard the slice and the partial packet; no closing beat is generated.

Configuration
REQ-020 Macro STREAM_ARB_WATCHDOG_EN SHALL compile in a counter: in BUSY, count consecutive cycles with s_valid_in[grant]=0 and an empty or drained slice.
REQ-021 With macro: when count reaches WATCHDOG_CYCLES, SHALL load slice with keep=0, last=1, data=0, pulse wd_abort_out 1 cycle, return IDLE; counter clears on any granted accept.
REQ-022 Without macro: no counter, wd_abort_out constant 0, BUSY held indefinitely.

Verification
REQ-023 Inputs 0,1,2 each valid with 2-beat packet, m_ready_in=1 -> packets output in order 0,1,2, m_grant_out 0,0,1,1,2,2, one bubble between packets.
REQ-024 After grant 2 completes, inputs 0 and 2 valid -> input 0 granted next (round-robin wrap), then 2.
REQ-025 Input 1 sends data 3'b101 keep 3'b111, m_ready_in=0 for 5 cycles -> m_valid_out=1, m_data_out=3'b101 stable, s_ready_out[1]=0 until release.
REQ-026 rst_n low for 1 cycle mid-packet on input 0 -> all outputs 0 same cycle; after release input 0 re-granted from packet start.
REQ-027 With STREAM_ARB_WATCHDOG_EN, WATCHDOG_CYCLES=4, input 2 sends 1 non-last beat then drops valid -> after 4 idle cycles output beat keep=0 last=1, wd_abort_out pulse, FSM IDLE.
REQ-028 Without macro, same stimulus -> no abort beat, wd_abort_out=0, grant stays 2 for 50 cycles.
